// File: rtl/icache_pkg.sv
// Shared definitions for the instruction cache and its miss-refill controller.
// Address field positions are common to both so they agree on the line layout.
package icache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DONE,
        ERROR
    } refill_state_t;

    localparam int unsigned WORDS_PER_LINE = 4;
    localparam int unsigned LINE_W         = 128;

    // Byte address fields: [3:2] word in line, [6:4] line index, [31:7] tag.
    localparam int unsigned OFFSET_LSB = 2;
    localparam int unsigned OFFSET_MSB = 3;
    localparam int unsigned INDEX_LSB  = 4;
    localparam int unsigned INDEX_MSB  = 6;
    localparam int unsigned TAG_LSB    = 7;
    localparam int unsigned TAG_MSB    = 31;

endpackage

// File: rtl/refill_wait_timer.sv
// Counts consecutive wait cycles on one memory beat.
// expired is high in the cycle whose end would be the TERMINAL-th wait.
module refill_wait_timer #(
    parameter int unsigned TERMINAL = 255
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CNT_W = $clog2(TERMINAL + 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign expired = enable && !clear && (count_q == CNT_W'(TERMINAL - 1));

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != CNT_W'(TERMINAL))) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/icache_refill_ctrl.sv
// Instruction cache miss-refill controller: fetches the four words of a missing
// line in order, presents the assembled line for one cycle and stalls fetch meanwhile.
module icache_refill_ctrl #(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned WORD_W         = 32,
    parameter int unsigned WORDS_PER_LINE = 4,
    parameter int unsigned TIMEOUT        = 255
) (
    input  logic                             clock,
    input  logic                             reset_n,
    input  logic                             miss_req,
    input  logic [ADDR_W-1:0]                miss_addr,
    output logic                             mem_req,
    output logic [ADDR_W-1:0]                mem_addr,
    input  logic                             mem_ready,
    input  logic [WORD_W-1:0]                mem_rdata,
    output logic                             line_valid,
    output logic [ADDR_W-1:0]                line_addr,
    output logic [WORD_W*WORDS_PER_LINE-1:0] data_line,
    output logic                             stall,
    output logic                             bus_error
);

    import icache_pkg::*;

    localparam int unsigned BEAT_W    = $clog2(WORDS_PER_LINE);
    localparam int unsigned LINE_BITS = WORD_W * WORDS_PER_LINE;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WORDS_PER_LINE - 1);
    localparam logic [ADDR_W-1:0] OFFSET_MASK = ADDR_W'((1 << INDEX_LSB) - 1);

    refill_state_t        state_q, state_d;
    logic [ADDR_W-1:0]    base_q, base_d;
    logic [BEAT_W-1:0]    beat_q, beat_d;
    logic [WORD_W-1:0]    line_buf_q [WORDS_PER_LINE];
    logic [WORD_W-1:0]    line_buf_d [WORDS_PER_LINE];
    logic                 mem_req_q, mem_req_d;
    logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
    logic                 line_valid_q, line_valid_d;
    logic [ADDR_W-1:0]    line_addr_q, line_addr_d;
    logic [LINE_BITS-1:0] data_line_q, data_line_d;
    logic                 stall_q, stall_d;
    logic                 bus_error_q, bus_error_d;

    logic                 beat_done;
    logic                 timer_expired;
    logic [BEAT_W-1:0]    beat_inc;
    logic [LINE_BITS-1:0] assembled;

    assign beat_done = (state_q == FETCH) && mem_req_q && mem_ready;
    assign beat_inc  = beat_q + BEAT_W'(1);

    refill_wait_timer #(
        .TERMINAL (TIMEOUT)
    ) u_wait_timer (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   ((state_q != FETCH) || beat_done),
        .enable  ((state_q == FETCH) && !beat_done),
        .expired (timer_expired)
    );

    always_comb begin
        for (int i = 0; i < WORDS_PER_LINE; i++) begin
            assembled[i*WORD_W +: WORD_W] = line_buf_d[i];
        end
    end

    // Outputs are computed for the state being entered so they can all be registered.
    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        beat_d       = beat_q;
        line_buf_d   = line_buf_q;
        mem_req_d    = 1'b0;
        mem_addr_d   = mem_addr_q;
        line_valid_d = 1'b0;
        line_addr_d  = line_addr_q;
        data_line_d  = data_line_q;
        stall_d      = 1'b0;
        bus_error_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (miss_req) begin
                    base_d     = miss_addr & ~OFFSET_MASK;
                    beat_d     = '0;
                    mem_addr_d = miss_addr & ~OFFSET_MASK;
                    mem_req_d  = 1'b1;
                    stall_d    = 1'b1;
                    state_d    = FETCH;
                end
            end
            FETCH: begin
                stall_d   = 1'b1;
                mem_req_d = 1'b1;
                if (beat_done) begin
                    line_buf_d[beat_q] = mem_rdata;
                    if (beat_q == LAST_BEAT) begin
                        data_line_d  = assembled;
                        line_addr_d  = base_q;
                        line_valid_d = 1'b1;
                        mem_req_d    = 1'b0;
                        state_d      = DONE;
                    end else begin
                        beat_d     = beat_inc;
                        mem_addr_d = base_q | (ADDR_W'(beat_inc) << OFFSET_LSB);
                    end
                end else if (timer_expired) begin
                    mem_req_d   = 1'b0;
                    bus_error_d = 1'b1;
                    state_d     = ERROR;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            ERROR: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            base_q       <= '0;
            beat_q       <= '0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
            line_valid_q <= 1'b0;
            line_addr_q  <= '0;
            data_line_q  <= '0;
            stall_q      <= 1'b0;
            bus_error_q  <= 1'b0;
            for (int i = 0; i < WORDS_PER_LINE; i++) begin
                line_buf_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            beat_q       <= beat_d;
            mem_req_q    <= mem_req_d;
            mem_addr_q   <= mem_addr_d;
            line_valid_q <= line_valid_d;
            line_addr_q  <= line_addr_d;
            data_line_q  <= data_line_d;
            stall_q      <= stall_d;
            bus_error_q  <= bus_error_d;
            for (int i = 0; i < WORDS_PER_LINE; i++) begin
                line_buf_q[i] <= line_buf_d[i];
            end
        end
    end

    assign mem_req    = mem_req_q;
    assign mem_addr   = mem_addr_q;
    assign line_valid = line_valid_q;
    assign line_addr  = line_addr_q;
    assign data_line  = data_line_q;
    assign stall      = stall_q;
    assign bus_error  = bus_error_q;

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Self-checking bench for icache_refill_ctrl: a memory responder with planned wait
// states feeds the DUT while a scoreboard holds expected beat addresses and line/error events.
module tb_icache_refill_ctrl;

    localparam int TB_TIMEOUT = 8;

    logic         clock;
    logic         reset_n;
    logic         miss_req;
    logic [31:0]  miss_addr;
    logic         mem_req;
    logic [31:0]  mem_addr;
    logic         mem_ready;
    logic [31:0]  mem_rdata;
    logic         line_valid;
    logic [31:0]  line_addr;
    logic [127:0] data_line;
    logic         stall;
    logic         bus_error;

    typedef struct {
        logic         is_err;
        logic [31:0]  addr;
        logic [127:0] data;
        int           due;
    } exp_t;

    exp_t         sb_q[$];
    logic [31:0]  addr_q[$];
    int           checks   = 0;
    int           failures = 0;
    int           cyc      = 0;
    int           plan_wait[4];
    int           plan_hang;
    int           resp_beat;
    int           resp_wait;
    logic [127:0] prev_line;
    logic [31:0]  prev_addr;

    icache_refill_ctrl #(
        .ADDR_W         (32),
        .WORD_W         (32),
        .WORDS_PER_LINE (4),
        .TIMEOUT        (TB_TIMEOUT)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .miss_req   (miss_req),
        .miss_addr  (miss_addr),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata),
        .line_valid (line_valid),
        .line_addr  (line_addr),
        .data_line  (data_line),
        .stall      (stall),
        .bus_error  (bus_error)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        forever begin
            @(posedge clock);
            cyc++;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog simulation did not finish checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Memory contents: line 0x40 holds 0x11..0x44, everything else is address-derived.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a[31:4] == 28'h4) begin
            return 32'h11 * (32'(a[3:2]) + 32'd1);
        end
        return {~a[15:0], a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    task automatic push_expect(input logic [31:0] a, input int n_acc);
        exp_t        e;
        logic [31:0] base;
        int          last;
        int          lat;
        base = a & 32'hFFFF_FFF0;
        last = (plan_hang >= 0) ? plan_hang : 3;
        for (int i = 0; i <= last; i++) begin
            addr_q.push_back(base + 32'(4 * i));
        end
        lat = 0;
        for (int i = 0; i < last; i++) begin
            lat += plan_wait[i] + 1;
        end
        if (plan_hang >= 0) begin
            lat += TB_TIMEOUT;
        end else begin
            lat += plan_wait[3] + 1;
        end
        e.is_err = (plan_hang >= 0);
        e.addr   = base;
        for (int i = 0; i < 4; i++) begin
            e.data[i*32 +: 32] = mem_word(base + 32'(4 * i));
        end
        e.due = n_acc + lat;
        sb_q.push_back(e);
    endtask

    // Call at negedge+1 with the DUT idle; returns at negedge+1 of the acceptance cycle.
    task automatic applyStimulus(input logic [31:0] a, input bit hold);
        push_expect(a, cyc + 1);
        miss_req  = 1'b1;
        miss_addr = a;
        @(negedge clock);
        #1;
        checkOutput("stall_accept", stall, 1);
        checkOutput("mem_req_accept", mem_req, 1);
        if (!hold) begin
            miss_req = 1'b0;
        end
    endtask

    task automatic wait_drain(input int limit);
        int n;
        n = 0;
        while ((sb_q.size() != 0 || addr_q.size() != 0) && n < limit) begin
            @(negedge clock);
            #1;
            n++;
        end
        checkOutput("drain", sb_q.size() + addr_q.size(), 0);
        @(negedge clock);
        #1;
        checkOutput("stall_idle", stall, 0);
        checkOutput("mem_req_idle", mem_req, 0);
        checkOutput("line_valid_pulse", line_valid, 0);
        checkOutput("bus_error_pulse", bus_error, 0);
    endtask

    task automatic check_reset_outputs();
        checkOutput("rst_mem_req", mem_req, 0);
        checkOutput("rst_line_valid", line_valid, 0);
        checkOutput("rst_stall", stall, 0);
        checkOutput("rst_bus_error", bus_error, 0);
        checkOutput("rst_mem_addr", mem_addr, 0);
        checkOutput("rst_line_addr", line_addr, 0);
        checkOutput("rst_data_line", data_line, 0);
    endtask

    // Memory responder and output monitor, both working on the falling edge.
    initial begin : responder
        exp_t e;
        mem_ready = 1'b0;
        mem_rdata = '0;
        resp_beat = 0;
        resp_wait = 0;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                mem_ready = 1'b0;
                resp_beat = 0;
                resp_wait = 0;
            end else begin
                if (line_valid) begin
                    checkOutput("line_expected", sb_q.size() > 0, 1);
                    if (sb_q.size() > 0) begin
                        e = sb_q.pop_front();
                        checkOutput("event_is_line", e.is_err, 0);
                        checkOutput("line_addr", line_addr, e.addr);
                        checkOutput("data_line", data_line, e.data);
                        checkOutput("line_cycle", cyc, e.due);
                        checkOutput("stall_done", stall, 1);
                        prev_line = e.data;
                        prev_addr = e.addr;
                    end
                end
                if (bus_error) begin
                    checkOutput("error_expected", sb_q.size() > 0, 1);
                    if (sb_q.size() > 0) begin
                        e = sb_q.pop_front();
                        checkOutput("event_is_error", e.is_err, 1);
                        checkOutput("error_cycle", cyc, e.due);
                    end
                    checkOutput("data_line_kept", data_line, prev_line);
                    checkOutput("line_addr_kept", line_addr, prev_addr);
                    checkOutput("stall_error", stall, 1);
                    checkOutput("error_beats_left", addr_q.size(), 1);
                    addr_q.delete();
                    resp_beat = 0;
                    resp_wait = 0;
                end
                if (mem_req) begin
                    checkOutput("addr_pending", addr_q.size() > 0, 1);
                    if (addr_q.size() > 0) begin
                        checkOutput("mem_addr", mem_addr, addr_q[0]);
                    end
                    if (resp_beat == plan_hang || resp_wait < plan_wait[resp_beat]) begin
                        mem_ready = 1'b0;
                        resp_wait++;
                    end else begin
                        mem_ready = 1'b1;
                        mem_rdata = mem_word(mem_addr);
                        if (addr_q.size() > 0) begin
                            void'(addr_q.pop_front());
                        end
                        resp_wait = 0;
                        resp_beat = (resp_beat == 3) ? 0 : resp_beat + 1;
                    end
                end else begin
                    mem_ready = 1'($urandom_range(0, 1));
                    mem_rdata = $urandom;
                end
            end
        end
    end

    initial begin : main
        int due1;
        reset_n   = 1'b0;
        miss_req  = 1'b0;
        miss_addr = '0;
        plan_hang = -1;
        plan_wait = '{0, 0, 0, 0};
        prev_line = '0;
        prev_addr = '0;
        repeat (3) @(negedge clock);
        #1;
        check_reset_outputs();
        reset_n = 1'b1;
        @(negedge clock);
        #1;

        $display("[TB] zero-wait refill at 0x40");
        applyStimulus(32'h0000_0040, 1'b0);
        wait_drain(50);

        $display("[TB] refill with wait states");
        plan_wait = '{0, 2, 0, 3};
        applyStimulus(32'h0000_0080, 1'b0);
        wait_drain(50);
        plan_wait = '{0, 0, 0, 0};

        $display("[TB] unaligned miss 0x1238");
        applyStimulus(32'h0000_1238, 1'b0);
        wait_drain(50);

        $display("[TB] timeout on beat 2");
        plan_hang = 2;
        applyStimulus(32'h0000_2000, 1'b0);
        wait_drain(50);
        plan_hang = -1;

        $display("[TB] reset during beat 2");
        applyStimulus(32'h0000_3004, 1'b0);
        repeat (2) @(negedge clock);
        #1;
        reset_n = 1'b0;
        #1;
        check_reset_outputs();
        sb_q.delete();
        addr_q.delete();
        prev_line = '0;
        prev_addr = '0;
        repeat (2) @(negedge clock);
        #1;
        reset_n = 1'b1;
        @(negedge clock);
        #1;
        applyStimulus(32'h0000_3000, 1'b0);
        wait_drain(50);

        $display("[TB] miss_req held high with changing address");
        applyStimulus(32'h0000_5010, 1'b1);
        due1 = cyc + 4;
        while (cyc < due1) begin
            miss_addr = 32'h0000_9000 + 32'(cyc) * 32'd16;
            @(negedge clock);
            #1;
        end
        push_expect(32'h0000_6020, cyc + 2);
        miss_addr = 32'h0000_6020;
        repeat (2) @(negedge clock);
        #1;
        checkOutput("stall_second", stall, 1);
        miss_req = 1'b0;
        wait_drain(50);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
